// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit types and line levels
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_block_if.sv
// rtl/uart_tx_block_if.sv - host/pad side signals of the UART transmitter
interface uart_tx_block_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_ready;
    logic                 serial_out;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_ready,
        input  serial_out,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_ready,
        output serial_out,
        output tx_done
    );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter that wraps to zero after rollover_val
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == rollover_val) ? '0 : count_out + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_timer.sv
// rtl/uart_tx_timer.sv - bit-period timer; bit_tick marks the last clock of each bit
module uart_tx_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    flex_counter #(.WIDTH(CW)) u_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (enable),
        .rollover_val (LAST),
        .count_out    (count)
    );

    assign bit_tick = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_block.sv
// rtl/uart_tx_block.sv - UART transmitter top; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input logic            clk,
    input logic            n_rst,
    uart_tx_block_if.slave bus
);

    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [BW-1:0]        bit_idx, idx_next;
    logic                 serial_r, serial_next;
    logic                 ready_r, done_r, done_next;
    logic                 accept, bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    uart_tx_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .enable   (state != IDLE),
        .clear    (accept),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            serial_r <= LINE_IDLE;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_idx  <= idx_next;
            serial_r <= serial_next;
            ready_r  <= (state_next == IDLE);
            done_r   <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as accepted, since shreg is consumed by shifting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_r <= 1'b0;
        end else if (accept) begin
            parity_r <= ^bus.tx_data;
        end
    end
`endif

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = bit_idx;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tx_start && ready_r) begin
                    accept     = 1'b1;
                    state_next = START;
                    shreg_next = bus.tx_data;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_next = shreg >> 1;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = bit_idx + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is decided from the upcoming state so serial_out can be a flop.
        case (state_next)
            START:   serial_next = START_BIT;
            DATA:    serial_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_next = parity_r;
`endif
            STOP:    serial_next = STOP_BIT;
            default: serial_next = LINE_IDLE;
        endcase
    end

    assign bus.serial_out = serial_r;
    assign bus.tx_ready   = ready_r;
    assign bus.tx_done    = done_r;

endmodule

// File: tb/tb_uart_tx_block.sv
// tb/tb_uart_tx_block.sv - scoreboard bench for uart_tx_block (honours UART_TX_PARITY_EN)
`timescale 1ns/1ps
module tb_uart_tx_block;

    localparam int C  = 10;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FB = DB + 3;
`else
    localparam int FB = DB + 2;
`endif
    localparam int FRAME_CYC = FB * C;

    typedef struct {
        logic [DB-1:0] data;
        int            start;
    } frame_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   free_at = 0;
    frame_t exp_q[$];
    int     done_q[$];

    uart_tx_block_if #(.DATA_BITS(DB)) bus ();

    uart_tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    function automatic logic [FB-1:0] frame_levels(input logic [DB-1:0] d);
        logic [FB-1:0] lv;
        int ones;
        ones  = 0;
        lv[0] = 1'b0;
        for (int i = 0; i < DB; i++) begin
            lv[1+i] = d[i];
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        lv[DB+1] = (ones % 2 == 1);
`endif
        lv[FB-1] = 1'b1;
        return lv;
    endfunction

    task automatic drive(input logic start, input logic [DB-1:0] d, output bit acc);
        @(posedge clk);
        #1;
        bus.tx_start = start;
        bus.tx_data  = d;
        acc = 0;
        if (start && n_rst && cyc >= free_at) begin
            exp_q.push_back('{data: d, start: cyc + 1});
            free_at = cyc + 1 + FRAME_CYC;
            acc = 1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive(1'b0, DB'($urandom), acc);
    endtask

    task automatic send(input logic [DB-1:0] d);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 2 * FRAME_CYC) begin
            drive(1'b1, d, acc);
            tries++;
        end
        idle(1);
    endtask

    task automatic wait_idle();
        bit acc;
        while (cyc < free_at) drive(1'b0, DB'($urandom), acc);
        idle(2);
    endtask

    initial begin : monitor
        frame_t        f;
        logic [FB-1:0] lv;
        bit            aborted;
        bit            bit_ok;
        forever begin
            @(negedge clk);
            if (!n_rst) continue;
            if (bus.serial_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("frame_expected", 0, 1);
                    repeat (FRAME_CYC) @(negedge clk);
                    continue;
                end
                f  = exp_q.pop_front();
                lv = frame_levels(f.data);
                check("start_cycle", cyc, f.start);
                aborted = 0;
                for (int b = 0; b < FB && !aborted; b++) begin
                    bit_ok = 1;
                    for (int k = 0; k < C && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (!n_rst) aborted = 1;
                        else if (bus.serial_out !== lv[b] || bus.tx_ready !== 1'b0 ||
                                 bus.tx_done !== 1'b0) bit_ok = 0;
                    end
                    if (!aborted) check($sformatf("frame_%02h_bit%0d", f.data, b), bit_ok, 1);
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (n_rst) begin
                        check("tx_done_pulse", bus.tx_done, 1);
                        check("tx_ready_after_frame", bus.tx_ready, 1);
                        check("done_cycle", cyc, f.start + FRAME_CYC);
                        done_q.push_back(cyc);
                    end
                end
            end else begin
                check("idle_line_high", bus.serial_out, 1);
                check("idle_done_low", bus.tx_done, 0);
                check("idle_ready_high", bus.tx_ready, 1);
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int n;
        int guard;
        int st;
        int dones_before;

        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        #12;
        check("reset_serial_out", bus.serial_out, 1);
        check("reset_tx_ready", bus.tx_ready, 1);
        check("reset_tx_done", bus.tx_done, 0);
        @(posedge clk);
        #1;
        n_rst   = 1'b1;
        free_at = cyc;
        idle(20);

        send(8'hA5);
        wait_idle();

        send(8'h5A);
        for (int i = 0; i < 50; i++) drive(1'b1, 8'hFF, acc);
        wait_idle();

        n     = 0;
        guard = 0;
        while (n < 2 && guard < 3 * FRAME_CYC) begin
            drive(1'b1, (n == 0) ? 8'h00 : 8'hFF, acc);
            if (acc) n++;
            guard++;
        end
        idle(1);
        wait_idle();
        if (done_q.size() >= 2)
            check("b2b_done_spacing", done_q[done_q.size()-1] - done_q[done_q.size()-2], FRAME_CYC + 1);
        else
            check("b2b_done_count", done_q.size(), 2);

        send(8'h96);
        st = free_at - FRAME_CYC;
        while (cyc < st + 4 * C + 4) drive(1'b0, DB'($urandom), acc);
        dones_before = done_q.size();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_serial_high", bus.serial_out, 1);
        check("async_reset_ready", bus.tx_ready, 1);
        check("async_reset_done_low", bus.tx_done, 0);
        repeat (3) @(posedge clk);
        #1;
        n_rst   = 1'b1;
        free_at = cyc;
        check("no_done_after_abort", done_q.size(), dones_before);
        send(8'h3C);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_idle();
        send(8'h03);
        wait_idle();
`endif

        for (int i = 0; i < 600; i++) drive($urandom_range(0, 3) == 0, DB'($urandom), acc);
        wait_idle();

        idle(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
